// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed common-anode 7-segment scanner.
// Captures a packed multi-digit value into shadows, scans one digit per
// slot with a leading blank interval, and decodes each nibble to active-low
// segments. Handles leading-zero suppression, per-digit blink and decimal
// points.

// Per-digit darkening logic: blink and leading-zero suppression.
module seg_lane (
    input  logic [3:0] nib,
    input  logic       upper_zero,  // every nibble above this one is zero
    input  logic       lz_ok,       // this digit may be suppressed
    input  logic       blink,
    input  logic       blink_ph,
    output logic       zero_here,   // this nibble and all above are zero
    output logic       dark
);
    assign zero_here = (nib == 4'd0) && upper_zero;
    assign dark      = (blink && blink_ph) || (lz_ok && zero_here);
endmodule

module seg_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int BLINK_DIV    = 25000000,
    parameter bit HEX_MODE     = 1'b0,
    parameter bit LZ_SUPPRESS  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_en,
    output logic [6:0]              disp,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    scan_tick
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] SEG_E = 7'b0000110;

    logic [NUM_DIGITS-1:0][3:0] val_q;
    logic [NUM_DIGITS-1:0]      dp_q;
    logic [NUM_DIGITS-1:0]      blink_q;
    logic [DW-1:0]              div_cnt;
    logic [IW-1:0]              idx;
    logic [BW-1:0]              blink_cnt;
    logic                       blink_ph;

    logic                       div_wrap;
    logic                       in_blank;
    logic [NUM_DIGITS:0]        zero_chain;
    logic [NUM_DIGITS-1:0]      lane_dark;
    logic                       dark;

    assign div_wrap = (div_cnt == DW'(CLK_DIV - 1));

    // Blank interval check; a zero-length interval must not compare unsigned < 0.
    generate
        if (BLANK_CYCLES == 0) begin : g_noblank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (div_cnt < DW'(BLANK_CYCLES));
        end
    endgenerate

    // Zero chain runs from the top digit down so each lane knows whether
    // it and everything to its left is zero.
    assign zero_chain[NUM_DIGITS] = 1'b1;

    generate
        for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_lane
            seg_lane u_lane (
                .nib        (val_q[k]),
                .upper_zero (zero_chain[k+1]),
                .lz_ok      (LZ_SUPPRESS && (k != 0)),
                .blink      (blink_q[k]),
                .blink_ph   (blink_ph),
                .zero_here  (zero_chain[k]),
                .dark       (lane_dark[k])
            );
        end
    endgenerate

    assign dark = in_blank || lane_dark[idx];

    function automatic logic [6:0] seg_decode(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_E;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            4'hA: s = HEX_MODE ? 7'b0001000 : SEG_E;
            4'hB: s = HEX_MODE ? 7'b0000011 : SEG_E;
            4'hC: s = HEX_MODE ? 7'b1000110 : SEG_E;
            4'hD: s = HEX_MODE ? 7'b0100001 : SEG_E;
            4'hE: s = SEG_E;
            4'hF: s = HEX_MODE ? 7'b0001110 : SEG_E;
            default: s = SEG_E;
        endcase
        return s;
    endfunction

    // Shadow capture, slot/digit scan counters and blink phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q     <= '0;
            dp_q      <= '0;
            blink_q   <= '0;
            div_cnt   <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else begin
            if (load) begin
                val_q   <= value;
                dp_q    <= dp_in;
                blink_q <= blink_en;
            end
            if (div_wrap) begin
                div_cnt <= '0;
                idx     <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // Registered pin drive: one cycle behind the scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= '1;
            disp      <= 7'h7F;
            dp        <= 1'b1;
            scan_tick <= 1'b0;
        end else begin
            scan_tick <= div_wrap && (idx == IW'(NUM_DIGITS - 1));
            if (dark) begin
                an   <= '1;
                disp <= 7'h7F;
                dp   <= 1'b1;
            end else begin
                an   <= ~(NUM_DIGITS'(1) << idx);
                disp <= seg_decode(val_q[idx]);
                dp   <= ~dp_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: two instances (decimal+LZ, hex
// without LZ) checked every cycle against a cycle-count based model.
module tb_seg_scan_driver;
    localparam int ND    = 4;
    localparam int CLK   = 4;
    localparam int BLANK = 1;
    localparam int BDIV  = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blink_en = '0;

    logic [6:0] disp0, disp1;
    logic       dp0, dp1, tick0, tick1;
    logic [3:0] an0, an1;

    int checks = 0;
    int failures = 0;

    // model state: cycles since reset release plus shadow copies
    int          c = 0;
    logic [15:0] sv = '0;
    logic [3:0]  sdp = '0;
    logic [3:0]  sbl = '0;

    seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CLK), .BLANK_CYCLES(BLANK),
                      .BLINK_DIV(BDIV), .HEX_MODE(1'b0), .LZ_SUPPRESS(1'b1)) u_dec (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blink_en(blink_en), .disp(disp0), .dp(dp0), .an(an0), .scan_tick(tick0));

    seg_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CLK), .BLANK_CYCLES(BLANK),
                      .BLINK_DIV(BDIV), .HEX_MODE(1'b1), .LZ_SUPPRESS(1'b0)) u_hex (
        .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
        .blink_en(blink_en), .disp(disp1), .dp(dp1), .an(an1), .scan_tick(tick1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n, input bit hex);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0011000;
            default: s = 7'b0000110;
        endcase
        if (hex) begin
            case (n)
                4'hA: s = 7'b0001000;
                4'hB: s = 7'b0000011;
                4'hC: s = 7'b1000110;
                4'hD: s = 7'b0100001;
                4'hF: s = 7'b0001110;
                default: ;
            endcase
        end
        return s;
    endfunction

    // expected {an, disp, dp} produced from scan state at cycle count cc
    function automatic logic [11:0] model_out(input int cc, input bit hex, input bit lz);
        int   d;
        int   pos;
        bit   ph;
        bit   dark;
        logic [3:0] nib;
        d    = (cc / CLK) % ND;
        pos  = cc % CLK;
        ph   = ((cc / BDIV) % 2) == 1;
        nib  = 4'((sv >> (4 * d)) & 16'hF);
        dark = (pos < BLANK) || (sbl[d] && ph) || (lz && d != 0 && (sv >> (4 * d)) == 16'h0);
        if (dark) return {4'hF, 7'h7F, 1'b1};
        return {4'(~(1 << d)), glyph(nib, hex), ~sdp[d]};
    endfunction

    task automatic check_dark(input string tag);
        chk({tag, "_an0"}, 32'(an0), 32'hF);
        chk({tag, "_disp0"}, 32'(disp0), 32'h7F);
        chk({tag, "_dp0"}, 32'(dp0), 32'h1);
        chk({tag, "_tick0"}, 32'(tick0), 32'h0);
        chk({tag, "_an1"}, 32'(an1), 32'hF);
        chk({tag, "_disp1"}, 32'(disp1), 32'h7F);
        chk({tag, "_dp1"}, 32'(dp1), 32'h1);
        chk({tag, "_tick1"}, 32'(tick1), 32'h0);
    endtask

    task automatic step();
        logic [11:0] e0, e1;
        logic        et;
        @(posedge clk);
        e0 = model_out(c, 1'b0, 1'b1);
        e1 = model_out(c, 1'b1, 1'b0);
        c++;
        et = ((c % (ND * CLK)) == 0);
        if (load) begin
            sv  = value;
            sdp = dp_in;
            sbl = blink_en;
        end
        #1;
        chk("an_dec", 32'(an0), 32'(e0[11:8]));
        chk("disp_dec", 32'(disp0), 32'(e0[7:1]));
        chk("dp_dec", 32'(dp0), 32'(e0[0]));
        chk("tick_dec", 32'(tick0), 32'(et));
        chk("an_hex", 32'(an1), 32'(e1[11:8]));
        chk("disp_hex", 32'(disp1), 32'(e1[7:1]));
        chk("dp_hex", 32'(dp1), 32'(e1[0]));
        chk("tick_hex", 32'(tick1), 32'(et));
    endtask

    task automatic load_and_run(input logic [15:0] v, input logic [3:0] dpv,
                                input logic [3:0] bl, input int cycles);
        value = v; dp_in = dpv; blink_en = bl; load = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < cycles; i++) step();
    endtask

    task automatic reset_model();
        c = 0; sv = '0; sdp = '0; sbl = '0;
    endtask

    initial begin
        logic [15:0] mask;
        int          guard;
        // reset held with load asserted: outputs stay dark, shadows stay zero
        value = 16'h1234; load = 1'b1; dp_in = 4'hF; blink_en = 4'h0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_dark("rst");
        end
        rst_n = 1'b1;
        load  = 1'b0;
        reset_model();
        for (int i = 0; i < 20; i++) step();

        // scan / decode / leading-zero / blink / dp patterns
        load_and_run(16'h1234, 4'h0, 4'h0, 40);
        load_and_run(16'h0042, 4'h0, 4'h0, 20);
        load_and_run(16'h0000, 4'h0, 4'h0, 20);
        load_and_run(16'h0402, 4'h0, 4'h0, 20);
        load_and_run(16'hA0AF, 4'h0, 4'h0, 20);
        load_and_run(16'hBCDE, 4'h0, 4'h0, 20);
        load_and_run(16'h5678, 4'b0100, 4'b0010, 48);
        load_and_run(16'h9000, 4'b1001, 4'b1000, 32);

        // load held high: shadows track inputs every cycle
        load = 1'b1;
        for (int i = 0; i < 24; i++) begin
            value = 16'($urandom); dp_in = 4'($urandom); blink_en = 4'($urandom);
            step();
        end
        load = 1'b0;

        // random traffic with sparse loads and frequent leading zeros
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 4))
                0: mask = 16'hFFFF;
                1: mask = 16'h0FFF;
                2: mask = 16'h00FF;
                3: mask = 16'h000F;
                default: mask = 16'h0000;
            endcase
            value    = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            blink_en = 4'($urandom);
            load     = ($urandom_range(0, 7) == 0);
            step();
        end
        load = 1'b0;

        // mid-scan async reset in slot 2, div_cnt 2
        load_and_run(16'h1234, 4'hF, 4'h0, 0);
        guard = 0;
        while ((c % (ND * CLK)) != (2 * CLK + 2) && guard < 64) begin
            step();
            guard++;
        end
        chk("midrst_reach", 32'(guard < 64), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_dark("midrst");
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_dark("midrst_hold");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        load_and_run(16'h1234, 4'h0, 4'h0, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
